alu_multiword_sequencer: RTL and testbench
==========================================

Name: alu_multiword_sequencer

Overview:
- Issue/sequencing stage wrapped around the 6-bit ripple ALU.
- Accepts wide operand requests on a valid/ready handshake.
- Feeds the ALU one 6-bit slice per cycle, LSB slice first, and chains each slice's CarryOut into the next slice's CarryIn through a register.
- Collects the result slices and returns the wide result, final carry and zero flag on a valid/ready response handshake.

Parameters:
SLICE_W, 6, ALU datapath width; fixed to match the ALU instance
NUM_SLICES, 2, slices per operand; operand width W = SLICE_W*NUM_SLICES (default 12)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  sequencer can accept a request
req_op  in  3  0=AND 1=OR 2=ADD 3=SUB 4=NOR, 5-7 reserved
req_a  in  W  operand A
req_b  in  W  operand B
alu_a  out  SLICE_W  slice of A driven to the ALU
alu_b  out  SLICE_W  slice of B driven to the ALU
alu_carry_in  out  1  ALU CarryIn
alu_op  out  4  ALU ALUOp
alu_result  in  SLICE_W  ALU Result (combinational from alu_* outputs)
alu_carry_out  in  1  ALU CarryOut
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts the response
rsp_result  out  W  assembled result
rsp_carry  out  1  final carry; 0 for logic ops
rsp_zero  out  1  rsp_result == 0

Behaviour:
- Reset (async, rst_n=0): state IDLE, slice index 0, all registers 0.
  - Outputs at reset: req_ready=1, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_zero=0.
  - alu_a=0, alu_b=0, alu_carry_in=0, alu_op=ALU_AND.
- ALUOp mapping: AND=4'b0000, OR=4'b0001, ADD=4'b0010, SUB=4'b0110, NOR=4'b1100.
  - Reserved req_op 5-7 are accepted and executed as AND.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge: latch op, A and B; idx<=0; carry_reg<=1 for SUB, else 0; go to RUN.
- RUN:
  - req_ready=0.
  - Drive alu_a=A[idx*SLICE_W +: SLICE_W], alu_b likewise, alu_carry_in=carry_reg, alu_op=mapped op.
  - Each edge: result_reg slice idx <= alu_result.
  - carry_reg <= alu_carry_out for ADD/SUB; held 0 for logic ops.
  - At idx==NUM_SLICES-1: go to DONE; otherwise idx<=idx+1.
- DONE:
  - rsp_valid=1. rsp_result, rsp_carry and rsp_zero are registered and held stable until the handshake.
  - On rsp_ready: go to IDLE and drop rsp_valid.
- Outside RUN: ALU drive outputs return to their reset values.
- Latency: rsp_valid rises NUM_SLICES cycles after the accept edge.
- Throughput: req_ready is asserted only in IDLE, so back-to-back requests take at least NUM_SLICES+2 cycles each.
- SUB carry convention: carry=1 means no borrow.
- rsp_ready while not DONE is ignored.
- req_valid while req_ready=0 is ignored.
- Reset mid-RUN or mid-DONE aborts the operation: the in-flight result is discarded and no response is issued.

Optional Feature:
- Macro: ALU_SEQ_OVERFLOW_EN.
- Defined: adds output rsp_overflow (1 bit) = signed overflow of the W-bit ADD/SUB, taken from the carry into and out of the MSB.
  - Carry into the MSB: the top slice recomputes it as alu_result[MSB] ^ alu_a[MSB] ^ alu_b_eff[MSB], where alu_b_eff = ~alu_b for SUB.
  - rsp_overflow is 0 for logic ops, resets to 0, and is held with the response.
- Undefined: port and logic absent.

Decomposition:
- Package alu_seq_pkg holds:
  - SLICE_W.
  - ALU_AND/ALU_OR/ALU_ADD/ALU_SUB/ALU_NOR 4-bit ALUOp constants.
  - REQ_* 3-bit request opcodes.
  - State encoding IDLE/RUN/DONE.
  - The op-mapping function (req_op -> ALUOp, initial carry).
- No sub-module: the ALU is instantiated alongside the sequencer at the parent level; slice select and collect stay inline.

Test Plan:
- ADD A=0x03F, B=0x001 -> rsp_result=0x040, rsp_carry=0, rsp_zero=0; carry crosses the slice boundary (slice 1 sees alu_carry_in=1).
- ADD 0xFFF+0x001 -> rsp_result=0x000, rsp_carry=1, rsp_zero=1.
- SUB 0x100-0x001 -> 0x0FF, carry=1. SUB 0x000-0x001 -> 0xFFF, carry=0.
- NOR 0x0F0,0x00F -> 0xF00, carry=0. Reserved op 7 with 0xABC,0x0F0 -> 0x0B0 (AND).
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable, req_ready=0, new req_valid ignored. Then rsp_ready=1 -> IDLE next cycle, next request accepted.
- Deassert rst_n during RUN slice 1 -> immediate reset values, no rsp_valid afterwards.
- With ALU_SEQ_OVERFLOW_EN: 0x7FF+0x001 -> 0x800, rsp_overflow=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : shared constants, types and op mapping for the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam int SLICE_W = 6;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [2:0] REQ_AND = 3'd0;
  localparam logic [2:0] REQ_OR  = 3'd1;
  localparam logic [2:0] REQ_ADD = 3'd2;
  localparam logic [2:0] REQ_SUB = 3'd3;
  localparam logic [2:0] REQ_NOR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       carry_init;
    logic       arith;
  } op_cfg_t;

  // Reserved request opcodes fall through to AND.
  function automatic op_cfg_t map_op(input logic [2:0] req_op);
    op_cfg_t cfg;
    cfg.alu_op     = ALU_AND;
    cfg.carry_init = 1'b0;
    cfg.arith      = 1'b0;
    case (req_op)
      REQ_OR:  cfg.alu_op = ALU_OR;
      REQ_ADD: begin
        cfg.alu_op = ALU_ADD;
        cfg.arith  = 1'b1;
      end
      REQ_SUB: begin
        cfg.alu_op     = ALU_SUB;
        cfg.carry_init = 1'b1;
        cfg.arith      = 1'b1;
      end
      REQ_NOR: cfg.alu_op = ALU_NOR;
      default: cfg.alu_op = ALU_AND;
    endcase
    return cfg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_multiword_sequencer.sv
// ============================================================================
// alu_multiword_sequencer : feeds a 6-bit ALU one slice per cycle, LSB first,
// chaining carry through a register. Optional macro ALU_SEQ_OVERFLOW_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_multiword_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_SLICES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [2:0]                      req_op,
  input  logic [SLICE_W*NUM_SLICES-1:0]   req_a,
  input  logic [SLICE_W*NUM_SLICES-1:0]   req_b,
  output logic [SLICE_W-1:0]              alu_a,
  output logic [SLICE_W-1:0]              alu_b,
  output logic                            alu_carry_in,
  output logic [3:0]                      alu_op,
  input  logic [SLICE_W-1:0]              alu_result,
  input  logic                            alu_carry_out,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [SLICE_W*NUM_SLICES-1:0]   rsp_result,
  output logic                            rsp_carry,
  output logic                            rsp_zero
`ifdef ALU_SEQ_OVERFLOW_EN
  ,
  output logic                            rsp_overflow
`endif
);

  localparam int W     = SLICE_W * NUM_SLICES;
  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       aluop_q, aluop_d;
  logic             arith_q, arith_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_q, carry_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;
  op_cfg_t          req_cfg;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic             ovf_q, ovf_d;
  logic             msb_cin;
`endif

  assign req_cfg = map_op(req_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      aluop_q     <= ALU_AND;
      arith_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      aluop_q     <= aluop_d;
      arith_q     <= arith_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
`ifdef ALU_SEQ_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    aluop_d      = aluop_q;
    arith_d      = arith_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    carry_d      = carry_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_carry_in = 1'b0;
    alu_op       = ALU_AND;
`ifdef ALU_SEQ_OVERFLOW_EN
    ovf_d        = ovf_q;
    msb_cin      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          aluop_d = req_cfg.alu_op;
          arith_d = req_cfg.arith;
          a_d     = req_a;
          b_d     = req_b;
          idx_d   = '0;
          carry_d = req_cfg.carry_init;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        alu_a        = a_q[idx_q*SLICE_W +: SLICE_W];
        alu_b        = b_q[idx_q*SLICE_W +: SLICE_W];
        alu_carry_in = carry_q;
        alu_op       = aluop_q;
        result_d[idx_q*SLICE_W +: SLICE_W] = alu_result;
        carry_d      = arith_q ? alu_carry_out : 1'b0;
        if (idx_q == LAST_IDX) begin
          // Flags are taken from the fully assembled next-state result.
          rsp_carry_d = carry_d;
          rsp_zero_d  = (result_d == '0);
`ifdef ALU_SEQ_OVERFLOW_EN
          msb_cin = alu_result[SLICE_W-1] ^ alu_a[SLICE_W-1] ^
                    ((aluop_q == ALU_SUB) ? ~alu_b[SLICE_W-1] : alu_b[SLICE_W-1]);
          ovf_d   = arith_q & (msb_cin ^ alu_carry_out);
`endif
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_result = result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_zero   = rsp_zero_q;
`ifdef ALU_SEQ_OVERFLOW_EN
  assign rsp_overflow = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_multiword_sequencer.sv
// ============================================================================
// tb_alu_multiword_sequencer : directed + random bench with a behavioural ALU
// and a wide-arithmetic reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_multiword_sequencer;
  import alu_seq_pkg::*;

  localparam int NS = 2;
  localparam int W  = SLICE_W * NS;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid, req_ready;
  logic [2:0]         req_op;
  logic [W-1:0]       req_a, req_b;
  logic [SLICE_W-1:0] alu_a, alu_b, alu_result;
  logic               alu_carry_in, alu_carry_out;
  logic [3:0]         alu_op;
  logic               rsp_valid, rsp_ready;
  logic [W-1:0]       rsp_result;
  logic               rsp_carry, rsp_zero;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic               rsp_overflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  alu_multiword_sequencer #(.NUM_SLICES(NS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_carry_in (alu_carry_in),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carry_out(alu_carry_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero)
`ifdef ALU_SEQ_OVERFLOW_EN
    ,
    .rsp_overflow (rsp_overflow)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural 6-bit ALU; its adder carry is exposed even for logic ops.
  logic [SLICE_W-1:0] m_b;
  logic [SLICE_W:0]   m_sum;
  always_comb begin
    m_b   = (alu_op == 4'b0110) ? ~alu_b : alu_b;
    m_sum = {1'b0, alu_a} + {1'b0, m_b} + {{SLICE_W{1'b0}}, alu_carry_in};
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = m_sum[SLICE_W-1:0];
      4'b0110: alu_result = m_sum[SLICE_W-1:0];
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
    alu_carry_out = m_sum[SLICE_W];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_aluop(input int op);
    case (op)
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0110;
      4: return 4'b1100;
      default: return 4'b0000;
    endcase
  endfunction

  // Carry entering slice k = carry out of the low k slices of the wide op.
  function automatic logic exp_cin(input int op, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    int mask, la, lb;
    if (op != 2 && op != 3) return 1'b0;
    if (k == 0) return (op == 3);
    mask = (1 << (SLICE_W * k)) - 1;
    la = int'(a) & mask;
    lb = int'(b) & mask;
    if (op == 2) return ((la + lb) >> (SLICE_W * k)) != 0;
    return la >= lb;
  endfunction

  task automatic ref_model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0] s;
    c = 1'b0;
    v = 1'b0;
    case (op)
      1: r = a | b;
      2: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3: begin
        r = a - b;
        c = (a >= b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4: r = ~(a | b);
      default: r = a & b;
    endcase
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({pfx, "_rsp_result"}, 32'(rsp_result), 32'd0);
    check_eq({pfx, "_rsp_carry"}, 32'(rsp_carry), 32'd0);
    check_eq({pfx, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
    check_eq({pfx, "_alu_a"}, 32'(alu_a), 32'd0);
    check_eq({pfx, "_alu_b"}, 32'(alu_b), 32'd0);
    check_eq({pfx, "_alu_cin"}, 32'(alu_carry_in), 32'd0);
    check_eq({pfx, "_alu_op"}, 32'(alu_op), 32'd0);
`ifdef ALU_SEQ_OVERFLOW_EN
    check_eq({pfx, "_rsp_ovf"}, 32'(rsp_overflow), 32'd0);
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] er;
    logic ec, ev;
    ref_model(op, a, b, er, ec, ev);
    check_eq("accept_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = 3'(op);
    req_a     = a;
    req_b     = b;
    rsp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_a     = W'($urandom);
    req_b     = W'($urandom);
    for (int k = 0; k < NS; k++) begin
      if (k > 0) @(negedge clk);
      check_eq("run_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("run_req_ready", 32'(req_ready), 32'd0);
      check_eq("slice_a", 32'(alu_a), 32'(a[k*SLICE_W +: SLICE_W]));
      check_eq("slice_b", 32'(alu_b), 32'(b[k*SLICE_W +: SLICE_W]));
      check_eq("slice_op", 32'(alu_op), 32'(exp_aluop(op)));
      check_eq("slice_cin", 32'(alu_carry_in), 32'(exp_cin(op, a, b, k)));
    end
    @(negedge clk);
    for (int h = 0; h <= hold; h++) begin
      check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("done_req_ready", 32'(req_ready), 32'd0);
      check_eq("rsp_result", 32'(rsp_result), 32'(er));
      check_eq("rsp_carry", 32'(rsp_carry), 32'(ec));
      check_eq("rsp_zero", 32'(rsp_zero), 32'(er == '0));
`ifdef ALU_SEQ_OVERFLOW_EN
      check_eq("rsp_overflow", 32'(rsp_overflow), 32'(ev));
`endif
      if (h < hold) begin
        req_valid = 1'b1;
        req_op    = 3'($urandom);
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        @(negedge clk);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2, 12'h03F, 12'h001, 0);
    run_op(2, 12'hFFF, 12'h001, 1);
    run_op(3, 12'h100, 12'h001, 0);
    run_op(3, 12'h000, 12'h001, 2);
    run_op(4, 12'h0F0, 12'h00F, 0);
    run_op(7, 12'hABC, 12'h0F0, 0);
    run_op(1, 12'hA50, 12'h05A, 5);
    run_op(0, 12'hF0F, 12'h0FF, 0);
    run_op(2, 12'h7FF, 12'h001, 0);
    run_op(3, 12'h800, 12'h001, 1);

    for (int i = 0; i < 60; i++) begin
      run_op(int'($urandom_range(0, 7)), W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end

    // Abort mid-operation: reset during slice 1 of an ADD.
    req_valid = 1'b1;
    req_op    = 3'd2;
    req_a     = 12'h7C1;
    req_b     = 12'h03F;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("abort_no_rsp", 32'(rsp_valid), 32'd0);
      check_eq("abort_ready", 32'(req_ready), 32'd1);
    end

    run_op(3, 12'h123, 12'h456, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
